// File: rtl/mpi_pkg.sv
// Shared MPI packet definitions: opcodes, envelope header bit positions,
// send FSM states, the latched send-request record and the header builder.
package mpi_pkg;

  localparam int unsigned HDR_W = 128;

  localparam logic [2:0] OP_EAGER     = 3'b001;
  localparam logic [2:0] OP_RTS       = 3'b010;
  localparam logic [2:0] OP_CTS       = 3'b011;
  localparam logic [2:0] OP_RNDV_DATA = 3'b100;

  localparam int unsigned HDR_EAGER_BIT = 127;
  localparam int unsigned HDR_OP_HI     = 122;
  localparam int unsigned HDR_OP_LO     = 120;
  localparam int unsigned HDR_TYPE_HI   = 119;
  localparam int unsigned HDR_TYPE_LO   = 112;
  localparam int unsigned HDR_COMM_HI   = 111;
  localparam int unsigned HDR_COMM_LO   = 104;
  localparam int unsigned HDR_SRC_HI    = 103;
  localparam int unsigned HDR_SRC_LO    = 96;
  localparam int unsigned HDR_TAG_HI    = 95;
  localparam int unsigned HDR_TAG_LO    = 88;
  localparam int unsigned HDR_DST_HI    = 87;
  localparam int unsigned HDR_DST_LO    = 80;
  localparam int unsigned HDR_LEN_HI    = 79;
  localparam int unsigned HDR_LEN_LO    = 64;
  localparam int unsigned HDR_PTR_HI    = 31;
  localparam int unsigned HDR_PTR_LO    = 0;

  typedef enum logic [2:0] {
    StIdle,
    StRts,
    StWaitCts,
    StHdr,
    StData
  } send_state_e;

  typedef struct packed {
    logic [7:0]  mtype;
    logic [7:0]  comm;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [7:0]  tag;
    logic [15:0] len;
    logic [31:0] ptr;
  } send_req_t;

  function automatic logic [HDR_W-1:0] build_hdr(input send_req_t req, input logic [2:0] op);
    logic [HDR_W-1:0] h;
    h                           = '0;
    h[HDR_EAGER_BIT]            = (op == OP_EAGER);
    h[HDR_OP_HI:HDR_OP_LO]      = op;
    h[HDR_TYPE_HI:HDR_TYPE_LO]  = req.mtype;
    h[HDR_COMM_HI:HDR_COMM_LO]  = req.comm;
    h[HDR_SRC_HI:HDR_SRC_LO]    = req.src;
    h[HDR_TAG_HI:HDR_TAG_LO]    = req.tag;
    h[HDR_DST_HI:HDR_DST_LO]    = req.dst;
    h[HDR_LEN_HI:HDR_LEN_LO]    = req.len;
    h[HDR_PTR_HI:HDR_PTR_LO]    = req.ptr;
    return h;
  endfunction

endpackage

// File: rtl/tx_skid_buffer.sv
// Two-entry flit FIFO between message-memory read data and the router port.
// The producer never pushes when full; the count output lets it gate reads.
module tx_skid_buffer #(
  parameter int unsigned WIDTH = 129
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign push      = in_valid;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/mpi_send_packetizer.sv
// Send-side packetizer: one send request becomes an eager header+payload, or an RTS,
// a CTS wait and a rendezvous header+payload, streamed to the router injection port.
module mpi_send_packetizer
  import mpi_pkg::*;
#(
  parameter int unsigned PKT_WIDTH       = 128,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned EAGER_MAX_FLITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_valid,
  output logic                  send_ready,
  input  logic [7:0]            send_type,
  input  logic [7:0]            send_comm,
  input  logic [7:0]            send_src,
  input  logic [7:0]            send_dst,
  input  logic [7:0]            send_tag,
  input  logic [15:0]           send_len,
  input  logic [31:0]           send_ptr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [PKT_WIDTH-1:0]  mem_rd_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [PKT_WIDTH-1:0]  tx_data,
  output logic                  tx_last,
  input  logic                  cts_valid,
  input  logic [7:0]            cts_comm,
  input  logic [7:0]            cts_src,
  input  logic [7:0]            cts_tag,
  output logic                  send_done,
  output logic                  cts_drop
);

  send_state_e           state_q, state_d;
  send_req_t             req_q, req_d;
  logic [2:0]            op_q, op_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_pend_q;
  logic                  rd_last_q, rd_last_d;
  logic                  cts_drop_q;

  logic                  skid_valid;
  logic                  skid_ready;
  logic [PKT_WIDTH:0]    skid_data;
  logic [1:0]            skid_count;
  logic [2:0]            skid_next;
  logic                  skid_pop;
  logic                  cts_match;
  logic [PKT_WIDTH-1:0]  hdr;

  assign hdr = build_hdr(req_q, op_q);

  assign cts_match = (state_q == StWaitCts) && cts_valid && (cts_comm == req_q.comm) &&
                     (cts_src == req_q.dst) && (cts_tag == req_q.tag);

  assign skid_ready = (state_q == StData) && tx_ready;
  assign skid_pop   = skid_valid && skid_ready;
  // Occupancy after this cycle's arriving read and pop; a new read lands one cycle later.
  assign skid_next  = {1'b0, skid_count} + {2'b0, rd_pend_q} - {2'b0, skid_pop};

  tx_skid_buffer #(
    .WIDTH(PKT_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_pend_q),
    .in_data  ({rd_last_q, mem_rd_data}),
    .out_valid(skid_valid),
    .out_ready(skid_ready),
    .out_data (skid_data),
    .count    (skid_count)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    op_d        = op_q;
    rd_cnt_d    = rd_cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_last_d   = rd_last_q;
    send_ready  = (state_q == StIdle) && !rst;
    mem_rd_en   = 1'b0;
    mem_rd_addr = rd_addr_q;
    tx_valid    = 1'b0;
    tx_data     = '0;
    tx_last     = 1'b0;
    send_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (send_valid) begin
          req_d = '{mtype: send_type, comm: send_comm, src: send_src, dst: send_dst,
                    tag: send_tag, len: send_len, ptr: send_ptr};
          if (send_len <= 16'(EAGER_MAX_FLITS)) begin
            op_d    = OP_EAGER;
            state_d = StHdr;
          end else begin
            op_d    = OP_RTS;
            state_d = StRts;
          end
        end
      end
      StRts: begin
        tx_valid = 1'b1;
        tx_data  = hdr;
        tx_last  = 1'b1;
        if (tx_ready) state_d = StWaitCts;
      end
      StWaitCts: begin
        if (cts_match) begin
          op_d    = OP_RNDV_DATA;
          state_d = StHdr;
        end
      end
      StHdr: begin
        tx_valid = 1'b1;
        tx_data  = hdr;
        tx_last  = (req_q.len == 16'd0);
        if (tx_ready) begin
          if (req_q.len == 16'd0) begin
            send_done = 1'b1;
            state_d   = StIdle;
          end else begin
            // First read goes out with the header handshake to hide memory latency.
            mem_rd_en   = 1'b1;
            mem_rd_addr = req_q.ptr[ADDR_WIDTH-1:0];
            rd_addr_d   = req_q.ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
            rd_cnt_d    = 16'd1;
            rd_last_d   = (req_q.len == 16'd1);
            state_d     = StData;
          end
        end
      end
      StData: begin
        tx_valid = skid_valid;
        tx_data  = skid_valid ? skid_data[PKT_WIDTH-1:0] : '0;
        tx_last  = skid_valid && skid_data[PKT_WIDTH];
        if ((rd_cnt_q != req_q.len) && (skid_next < 3'd2)) begin
          mem_rd_en = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          rd_cnt_d  = rd_cnt_q + 16'd1;
          rd_last_d = (rd_cnt_q == req_q.len - 16'd1);
        end
        if (skid_pop && skid_data[PKT_WIDTH]) begin
          send_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_q      <= '0;
      op_q       <= OP_EAGER;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_last_q  <= 1'b0;
      cts_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      op_q       <= op_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_pend_q  <= mem_rd_en;
      rd_last_q  <= rd_last_d;
      cts_drop_q <= cts_valid && !cts_match;
    end
  end

  assign cts_drop = cts_drop_q;

endmodule

// File: tb/tb_mpi_send_packetizer.sv
// Directed self-checking bench for mpi_send_packetizer: eager, zero-length,
// rendezvous, backpressure with address wrap, mid-packet reset and stray CTS.
module tb_mpi_send_packetizer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         send_valid = 1'b0;
  logic         send_ready;
  logic [7:0]   send_type = '0, send_comm = '0, send_src = '0, send_dst = '0, send_tag = '0;
  logic [15:0]  send_len = '0;
  logic [31:0]  send_ptr = '0;
  logic         mem_rd_en;
  logic [9:0]   mem_rd_addr;
  logic [127:0] mem_rd_data = '0;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic [127:0] tx_data;
  logic         tx_last;
  logic         cts_valid = 1'b0;
  logic [7:0]   cts_comm = '0, cts_src = '0, cts_tag = '0;
  logic         send_done;
  logic         cts_drop;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] cap_data[$];
  bit           cap_last[$];
  int           cap_cyc[$];
  int           n_done, n_rd, n_stab;
  bit           done_at_last, timeout;

  mpi_send_packetizer #(
    .PKT_WIDTH(128),
    .ADDR_WIDTH(10),
    .EAGER_MAX_FLITS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .send_valid (send_valid),
    .send_ready (send_ready),
    .send_type  (send_type),
    .send_comm  (send_comm),
    .send_src   (send_src),
    .send_dst   (send_dst),
    .send_tag   (send_tag),
    .send_len   (send_len),
    .send_ptr   (send_ptr),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .cts_valid  (cts_valid),
    .cts_comm   (cts_comm),
    .cts_src    (cts_src),
    .cts_tag    (cts_tag),
    .send_done  (send_done),
    .cts_drop   (cts_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mem_word(input logic [9:0] a);
    return {32'hC0DE_0000 + 32'(a), 64'hFEED_FACE_0000_0000, 22'h0, a};
  endfunction

  function automatic logic [127:0] exp_hdr(input bit eager, input logic [2:0] op,
                                           input logic [7:0] ty, input logic [7:0] comm,
                                           input logic [7:0] src, input logic [7:0] tag,
                                           input logic [7:0] dst, input logic [15:0] len,
                                           input logic [31:0] ptr);
    return {eager, 4'b0, op, ty, comm, src, tag, dst, len, 32'h0, ptr};
  endfunction

  // Message memory: one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);

  task automatic send_req(input logic [7:0] ty, input logic [7:0] comm, input logic [7:0] src,
                          input logic [7:0] dst, input logic [7:0] tag, input logic [15:0] len,
                          input logic [31:0] ptr);
    int k;
    @(negedge clk);
    send_type = ty; send_comm = comm; send_src = src; send_dst = dst;
    send_tag = tag; send_len = len; send_ptr = ptr; send_valid = 1'b1;
    #1;
    k = 0;
    while (!send_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    n_checks++;
    if (!send_ready) begin
      n_errors++;
      $display("FAIL send_ready_timeout: got %0b required 1", send_ready);
    end
    @(posedge clk);
    #1 send_valid = 1'b0;
  endtask

  // Captures handshaken flits until tx_last; toggle selects ready pattern 1,0,0,1,...
  task automatic collect(input int max_cyc, input bit toggle);
    bit stalled = 1'b0;
    bit got_last = 1'b0;
    logic [127:0] held = '0;
    cap_data.delete(); cap_last.delete(); cap_cyc.delete();
    n_done = 0; n_rd = 0; n_stab = 0; done_at_last = 1'b0;
    for (int c = 0; c < max_cyc && !got_last; c++) begin
      @(negedge clk);
      tx_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      #1;
      if (stalled && (!tx_valid || tx_data !== held)) n_stab++;
      if (send_done) n_done++;
      if (mem_rd_en) n_rd++;
      if (tx_valid && tx_ready) begin
        cap_data.push_back(tx_data);
        cap_last.push_back(tx_last);
        cap_cyc.push_back(c);
        if (tx_last) begin
          got_last = 1'b1;
          done_at_last = send_done;
        end
      end
      stalled = tx_valid && !tx_ready;
      held = tx_data;
    end
    tx_ready = 1'b1;
    timeout = !got_last;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++;
    if ({send_ready, mem_rd_en, tx_valid, tx_last, send_done, cts_drop} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {send_ready, mem_rd_en, tx_valid, tx_last, send_done, cts_drop});
    end
    n_checks++;
    if (tx_data !== 128'h0) begin
      n_errors++;
      $display("FAIL reset_tx_data: got %h required 0", tx_data);
    end
  endtask

  task automatic test_eager();
    logic [127:0] h;
    h = exp_hdr(1'b1, 3'b001, 8'h11, 8'd3, 8'd1, 8'd7, 8'd5, 16'd2, 32'h10);
    send_req(8'h11, 8'd3, 8'd1, 8'd5, 8'd7, 16'd2, 32'h10);
    collect(20, 1'b0);
    n_checks++;
    if (timeout || cap_data.size() != 3) begin
      n_errors++;
      $display("FAIL eager_count: got %0d flits required 3", cap_data.size());
    end else begin
      n_checks++;
      if (cap_data[0] !== h || cap_data[0][127] !== 1'b1) begin
        n_errors++;
        $display("FAIL eager_hdr: got %h required %h", cap_data[0], h);
      end
      n_checks++;
      if (cap_data[1] !== mem_word(10'h10) || cap_data[2] !== mem_word(10'h11)) begin
        n_errors++;
        $display("FAIL eager_data: got %h %h required %h %h", cap_data[1], cap_data[2],
                 mem_word(10'h10), mem_word(10'h11));
      end
      n_checks++;
      if ({cap_last[0], cap_last[1], cap_last[2]} !== 3'b001) begin
        n_errors++;
        $display("FAIL eager_last: got %b required 001",
                 {cap_last[0], cap_last[1], cap_last[2]});
      end
      n_checks++;
      if (cap_cyc[0] != 0 || cap_cyc[1] != 2 || cap_cyc[2] != 3) begin
        n_errors++;
        $display("FAIL eager_latency: got %0d %0d %0d required 0 2 3",
                 cap_cyc[0], cap_cyc[1], cap_cyc[2]);
      end
    end
    n_checks++;
    if (n_done != 1 || !done_at_last || n_rd != 2) begin
      n_errors++;
      $display("FAIL eager_done_rd: got done=%0d at_last=%0b rd=%0d required 1 1 2",
               n_done, done_at_last, n_rd);
    end
  endtask

  task automatic test_zero_len();
    logic [127:0] h;
    h = exp_hdr(1'b1, 3'b001, 8'h22, 8'd2, 8'd1, 8'd4, 8'd9, 16'd0, 32'h55);
    send_req(8'h22, 8'd2, 8'd1, 8'd9, 8'd4, 16'd0, 32'h55);
    collect(10, 1'b0);
    n_checks++;
    if (timeout || cap_data.size() != 1 || cap_data[0] !== h || !cap_last[0]) begin
      n_errors++;
      $display("FAIL zero_hdr: got n=%0d %h required n=1 %h last", cap_data.size(),
               (cap_data.size() > 0) ? cap_data[0] : 128'h0, h);
    end
    n_checks++;
    if (n_rd != 0 || n_done != 1 || !done_at_last) begin
      n_errors++;
      $display("FAIL zero_done_rd: got rd=%0d done=%0d at_last=%0b required 0 1 1",
               n_rd, n_done, done_at_last);
    end
  endtask

  task automatic test_rendezvous();
    logic [127:0] h_rts, h_rd;
    bit ok;
    h_rts = exp_hdr(1'b0, 3'b010, 8'h33, 8'd3, 8'd1, 8'd7, 8'd5, 16'd8, 32'h100);
    h_rd  = exp_hdr(1'b0, 3'b100, 8'h33, 8'd3, 8'd1, 8'd7, 8'd5, 16'd8, 32'h100);
    send_req(8'h33, 8'd3, 8'd1, 8'd5, 8'd7, 16'd8, 32'h100);
    collect(10, 1'b0);
    n_checks++;
    if (timeout || cap_data.size() != 1 || cap_data[0] !== h_rts || n_rd != 0) begin
      n_errors++;
      $display("FAIL rts_hdr: got n=%0d %h rd=%0d required n=1 %h rd=0", cap_data.size(),
               (cap_data.size() > 0) ? cap_data[0] : 128'h0, n_rd, h_rts);
    end
    @(negedge clk); #1;
    n_checks++;
    if (tx_valid || send_ready || send_done) begin
      n_errors++;
      $display("FAIL rts_wait_idle: got valid=%0b ready=%0b done=%0b required 0 0 0",
               tx_valid, send_ready, send_done);
    end
    cts_comm = 8'd3; cts_src = 8'd5; cts_tag = 8'd9; cts_valid = 1'b1;
    @(posedge clk); #1 cts_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (cts_drop !== 1'b1 || tx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL cts_wrong_tag: got drop=%0b valid=%0b required 1 0", cts_drop, tx_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (cts_drop !== 1'b0 || tx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL cts_drop_pulse: got drop=%0b valid=%0b required 0 0", cts_drop, tx_valid);
    end
    cts_tag = 8'd7; cts_valid = 1'b1;
    @(posedge clk); #1 cts_valid = 1'b0;
    collect(40, 1'b0);
    n_checks++;
    if (timeout || cap_data.size() != 9) begin
      n_errors++;
      $display("FAIL rndv_count: got %0d flits required 9", cap_data.size());
    end else begin
      n_checks++;
      if (cap_data[0] !== h_rd) begin
        n_errors++;
        $display("FAIL rndv_hdr: got %h required %h", cap_data[0], h_rd);
      end
      ok = 1'b1;
      for (int i = 1; i < 9; i++)
        if (cap_data[i] !== mem_word(10'(32'h100 + i - 1)) || cap_last[i] != (i == 8)) ok = 1'b0;
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL rndv_data: got last flit %h required %h", cap_data[8], mem_word(10'h107));
      end
      n_checks++;
      if (cap_cyc[8] != 9) begin
        n_errors++;
        $display("FAIL rndv_throughput: got last flit at cycle %0d required 9", cap_cyc[8]);
      end
    end
    n_checks++;
    if (n_done != 1 || !done_at_last) begin
      n_errors++;
      $display("FAIL rndv_done: got %0d at_last=%0b required 1 1", n_done, done_at_last);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] h;
    logic [9:0]   exp_a [4];
    bit ok;
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    h = exp_hdr(1'b1, 3'b001, 8'h44, 8'd6, 8'd2, 8'd8, 8'd3, 16'd4, 32'h3FE);
    send_req(8'h44, 8'd6, 8'd2, 8'd3, 8'd8, 16'd4, 32'h3FE);
    collect(60, 1'b1);
    n_checks++;
    if (timeout || cap_data.size() != 5) begin
      n_errors++;
      $display("FAIL bp_count: got %0d flits required 5", cap_data.size());
    end else begin
      ok = (cap_data[0] === h) && !cap_last[0];
      for (int i = 0; i < 4; i++)
        if (cap_data[i+1] !== mem_word(exp_a[i]) || cap_last[i+1] != (i == 3)) ok = 1'b0;
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL bp_order_wrap: got %h %h required %h %h", cap_data[3], cap_data[4],
                 mem_word(10'h000), mem_word(10'h001));
      end
    end
    n_checks++;
    if (n_stab != 0) begin
      n_errors++;
      $display("FAIL bp_stable: got %0d changes while stalled required 0", n_stab);
    end
    n_checks++;
    if (n_done != 1 || n_rd != 4) begin
      n_errors++;
      $display("FAIL bp_done_rd: got done=%0d rd=%0d required 1 4", n_done, n_rd);
    end
  endtask

  task automatic test_reset_mid_data();
    bit hit = 1'b0;
    send_req(8'h55, 8'd1, 8'd1, 8'd2, 8'd3, 16'd4, 32'h20);
    for (int c = 0; c < 12 && !hit; c++) begin
      @(negedge clk); #1;
      if (tx_valid && tx_data === mem_word(10'h21)) begin
        rst = 1'b1;
        hit = 1'b1;
      end
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL rst_mid_flit2: got no second data flit required one");
    end
    @(negedge clk); #1;
    n_checks++;
    if (tx_valid !== 1'b0 || send_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_outputs: got valid=%0b ready=%0b required 0 0", tx_valid, send_ready);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (send_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_release: got ready=%0b valid=%0b required 1 0", send_ready, tx_valid);
    end
    send_req(8'h66, 8'd1, 8'd1, 8'd2, 8'd3, 16'd1, 32'h40);
    collect(20, 1'b0);
    n_checks++;
    if (timeout || cap_data.size() != 2 || cap_data[1] !== mem_word(10'h40) || !cap_last[1] ||
        cap_data[0] !== exp_hdr(1'b1, 3'b001, 8'h66, 8'd1, 8'd1, 8'd3, 8'd2, 16'd1, 32'h40)) begin
      n_errors++;
      $display("FAIL rst_new_req: got n=%0d last data %h required n=2 %h", cap_data.size(),
               (cap_data.size() > 1) ? cap_data[1] : 128'h0, mem_word(10'h40));
    end
  endtask

  task automatic test_stray_cts();
    @(negedge clk);
    cts_comm = 8'd3; cts_src = 8'd5; cts_tag = 8'd7; cts_valid = 1'b1;
    @(posedge clk); #1 cts_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (cts_drop !== 1'b1 || send_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_cts: got drop=%0b ready=%0b valid=%0b required 1 1 0",
               cts_drop, send_ready, tx_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (cts_drop !== 1'b0 || send_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stray_cts_pulse: got drop=%0b ready=%0b required 0 1", cts_drop, send_ready);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_eager();
    test_zero_len();
    test_rendezvous();
    test_backpressure();
    test_reset_mid_data();
    test_stray_cts();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
